// File: rtl/rah_resp_arbiter_pkg.sv
// Shared constants and types for the RAH response arbiter and its peripherals.
package rah_resp_arbiter_pkg;

    // Response sources that feed the arbiter.
    localparam int TOTAL_UART       = 2;
    localparam int TOTAL_GPIO_CTRLS = 1;
    localparam int TOTAL_PWM        = 1;
    localparam int RAH_NUM_REQ      = TOTAL_UART + TOTAL_GPIO_CTRLS + TOTAL_PWM;

    // RAH packet beat width and downstream response FIFO depth.
    localparam int RAH_PKT_WIDTH  = 48;
    localparam int RAH_FIFO_DEPTH = 64;

    // Arbiter FSM encodings.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rah_state_e;

    // Position 'base + off' on a ring of 'n' requesters.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rah_resp_arbiter_rr_select.sv
// rr_select: round-robin priority pick. Searches upward from i_ptr+1 with
// wrap-around and returns the first requesting index.
module rr_select
    import rah_resp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = RAH_NUM_REQ,
    parameter int IDX_W   = $clog2(RAH_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    // First set request after the pointer; the pointer itself has lowest priority.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'(wrap_idx(int'(i_ptr), k, NUM_REQ));
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/rah_resp_arbiter.sv
// rah_resp_arbiter: grants one requester at a time and forwards its packet
// beats into the downstream response FIFO, throttled by FIFO occupancy.
module rah_resp_arbiter
    import rah_resp_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = RAH_NUM_REQ,
    parameter int PKT_WIDTH   = RAH_PKT_WIDTH,
    parameter int FIFO_DEPTH  = RAH_FIFO_DEPTH,
    parameter int CNT_WIDTH   = 8,
    parameter int FULL_MARGIN = 2,
    parameter int MAX_BEATS   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PKT_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [CNT_WIDTH-1:0]         fifo_datacount,
    output logic                         fifo_wr_en,
    output logic [PKT_WIDTH-1:0]         fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         burst_err
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_WIDTH:0]  SPACE_LIMIT = (CNT_WIDTH + 1)'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [BEAT_W-1:0]   LAST_BEAT   = BEAT_W'(MAX_BEATS - 1);

    rah_state_e          r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_wr_en;
    logic [PKT_WIDTH-1:0] r_wdata;
    logic                r_busy;
    logic                r_err;

    logic [CNT_WIDTH:0]   w_level;
    logic                 w_space;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_sel_any;
    logic                 w_gnt_valid;
    logic                 w_gnt_last;
    logic [PKT_WIDTH-1:0] w_gnt_data;
    logic                 w_accept;
    logic                 w_at_limit;

    // The write issued last cycle is not yet in the datacount, so count it here.
    assign w_level = {1'b0, fifo_datacount} + {{CNT_WIDTH{1'b0}}, r_wr_en};
    assign w_space = (w_level < SPACE_LIMIT);

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_idx (w_sel_idx),
        .o_any (w_sel_any)
    );

    // Steer the grantee's beat and drive ready only toward the grantee.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        w_gnt_data  = '0;
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_gnt_valid  = req_valid[i];
                w_gnt_last   = req_last[i];
                w_gnt_data   = req_data[i*PKT_WIDTH +: PKT_WIDTH];
                req_ready[i] = (r_state == ST_BURST) && w_space;
            end
        end
    end

    assign w_accept   = (r_state == ST_BURST) && w_gnt_valid && w_space;
    assign w_at_limit = (r_beat_cnt == LAST_BEAT);

    // Arbitration FSM, beat counter and registered FIFO write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_wr_en    <= 1'b0;
            // NOTE: the data register is reset too, since fifo_wdata is a visible output with a defined post-reset value.
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_any) begin
                        r_grant    <= w_sel_idx;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        r_wr_en <= 1'b1;
                        r_wdata <= w_gnt_data;
                        if (w_gnt_last || w_at_limit) begin
                            // Packet done (or overran MAX_BEATS): release and rotate.
                            r_err    <= !w_gnt_last;
                            r_rr_ptr <= r_grant;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_wr_en = r_wr_en;
    assign fifo_wdata = r_wdata;
    assign grant_id   = r_grant;
    assign busy       = r_busy;
    assign burst_err  = r_err;

endmodule

// File: tb/tb_rah_resp_arbiter.sv
// Self-checking bench for rah_resp_arbiter: directed scenarios plus a random
// phase, all compared cycle by cycle against a transaction-level model.
module tb_rah_resp_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int PKT_WIDTH   = 48;
    localparam int FIFO_DEPTH  = 64;
    localparam int CNT_WIDTH   = 8;
    localparam int FULL_MARGIN = 2;
    localparam int MAX_BEATS   = 16;
    localparam int IDX_W       = 2;

    typedef struct {
        logic [PKT_WIDTH-1:0] data;
        bit                   last;
    } beat_t;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PKT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic [CNT_WIDTH-1:0]         fifo_datacount;
    logic                         fifo_wr_en;
    logic [PKT_WIDTH-1:0]         fifo_wdata;
    logic [IDX_W-1:0]             grant_id;
    logic                         busy;
    logic                         burst_err;

    always #5 clk = ~clk;

    rah_resp_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .PKT_WIDTH   (PKT_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .FULL_MARGIN (FULL_MARGIN),
        .MAX_BEATS   (MAX_BEATS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_datacount (fifo_datacount),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wdata     (fifo_wdata),
        .grant_id       (grant_id),
        .busy           (busy),
        .burst_err      (burst_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Requester stimulus state.
    beat_t                bq[NUM_REQ][$];
    logic [PKT_WIDTH-1:0] exp_q[NUM_REQ][$];
    int                   valid_pct[NUM_REQ];
    bit                   gap_mode[NUM_REQ];
    int                   gap_ctr[NUM_REQ];
    bit [NUM_REQ-1:0]     acc_prev;
    int                   level;
    bit                   autofill;
    int                   drain_pct;
    int                   seq_no = 0;
    int                   total_enq;

    // Observations.
    logic [PKT_WIDTH-1:0] wr_log[$];
    int                   gnt_log[$];
    int                   err_pulses;
    bit                   prev_busy;

    // Reference model: who holds the grant, who was served last, beats so far.
    bit                   m_burst;
    int                   m_gnt;
    int                   m_last_served;
    int                   m_beats;
    bit                   m_wr;
    logic [PKT_WIDTH-1:0] m_wdata;
    bit                   m_err;

    task automatic model_reset();
        m_burst       = 1'b0;
        m_gnt         = 0;
        m_last_served = NUM_REQ - 1;
        m_beats       = 0;
        m_wr          = 1'b0;
        m_wdata       = '0;
        m_err         = 1'b0;
    endtask

    task automatic cfg_default();
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_pct[i] = 100;
            gap_mode[i]  = 1'b0;
            gap_ctr[i]   = 0;
        end
        autofill  = 1'b0;
        drain_pct = 0;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        gnt_log.delete();
        err_pulses = 0;
        for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
    endtask

    task automatic enq(input int r, input int nbeats, input bit with_last);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.data = {8'(r), 8'hA5, 32'(seq_no)};
            b.last = with_last && (k == nbeats - 1);
            seq_no++;
            total_enq++;
            bq[r].push_back(b);
            exp_q[r].push_back(b.data);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !acc_prev[i]) begin
                req_valid[i] = 1'b1;  // held until accepted
            end else if (bq[i].size() == 0) begin
                req_valid[i] = 1'b0;
            end else if (gap_mode[i]) begin
                req_valid[i] = (gap_ctr[i] % 3 == 0);
            end else begin
                req_valid[i] = ($urandom_range(99) < valid_pct[i]);
            end
            gap_ctr[i]++;
            if (bq[i].size() > 0) begin
                req_data[i*PKT_WIDTH +: PKT_WIDTH] = bq[i][0].data;
                req_last[i] = bq[i][0].last;
            end else begin
                req_data[i*PKT_WIDTH +: PKT_WIDTH] = '0;
                req_last[i] = 1'b0;
            end
        end
        fifo_datacount = CNT_WIDTH'(level);
    endtask

    // One clock: drive, compare at negedge, advance model, return to posedge+1.
    task automatic cycle();
        bit [NUM_REQ-1:0] exp_rdy;
        bit               space;
        bit               wr_obs;
        drive();
        space   = (level + int'(m_wr)) < (FIFO_DEPTH - FULL_MARGIN);
        exp_rdy = '0;
        if (m_burst && space) exp_rdy[m_gnt] = 1'b1;
        @(negedge clk);
        check("req_ready",  req_ready,  exp_rdy);
        check("fifo_wr_en", fifo_wr_en, m_wr);
        check("fifo_wdata", fifo_wdata, m_wdata);
        check("grant_id",   grant_id,   m_gnt);
        check("busy",       busy,       m_burst);
        check("burst_err",  burst_err,  m_err);
        wr_obs = fifo_wr_en;
        if (fifo_wr_en) wr_log.push_back(fifo_wdata);
        if (burst_err) err_pulses++;
        if (busy && !prev_busy) gnt_log.push_back(int'(grant_id));
        prev_busy = busy;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_prev[i] = req_valid[i] && req_ready[i];
            if (acc_prev[i]) void'(bq[i].pop_front());
        end
        // Model advance.
        m_wr  = 1'b0;
        m_err = 1'b0;
        if (!m_burst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int j;
                j = (m_last_served + k) % NUM_REQ;
                if (req_valid[j]) begin
                    m_gnt   = j;
                    m_burst = 1'b1;
                    m_beats = 0;
                    break;
                end
            end
        end else if (req_valid[m_gnt] && exp_rdy[m_gnt]) begin
            m_wr    = 1'b1;
            m_wdata = req_data[m_gnt*PKT_WIDTH +: PKT_WIDTH];
            m_beats++;
            if (req_last[m_gnt] || m_beats == MAX_BEATS) begin
                m_err         = !req_last[m_gnt];
                m_burst       = 1'b0;
                m_last_served = m_gnt;
            end
        end
        // Downstream FIFO occupancy.
        if (autofill && wr_obs) level++;
        if (drain_pct > 0 && level > 0 && $urandom_range(99) < drain_pct) level--;
        if (level > 255) level = 255;
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NUM_REQ; i++) if (bq[i].size() != 0) return 1'b0;
        return !m_burst && !m_wr && !m_err;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (all_done()) return;
            cycle();
        end
        check({tag, "_timeout"}, 1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) bq[i].delete();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        acc_prev  = '0;
        level     = 0;
        fifo_datacount = '0;
        prev_busy = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_ready",  req_ready,  0);
        check("rst_wr_en",  fifo_wr_en, 0);
        check("rst_wdata",  fifo_wdata, 0);
        check("rst_grant",  grant_id,   0);
        check("rst_busy",   busy,       0);
        check("rst_err",    burst_err,  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        total_enq = 0;
        cfg_default();
        clear_logs();
        do_reset();

        // Rotation after reset with all four requesting 1-beat packets.
        for (int i = 0; i < NUM_REQ; i++) enq(i, 1, 1'b1);
        for (int i = 0; i < NUM_REQ; i++) enq(i, 1, 1'b1);
        run_until_idle("rotate", 100);
        check("rotate_count", wr_log.size(), 8);
        if (wr_log.size() == 8)
            for (int k = 0; k < 8; k++) check("rotate_order", wr_log[k], exp_q[k % 4][k / 4]);

        // Requester 2 sends A,B,C.
        clear_logs();
        enq(2, 3, 1'b1);
        run_until_idle("req2_abc", 50);
        check("abc_count", wr_log.size(), 3);
        if (wr_log.size() == 3)
            for (int k = 0; k < 3; k++) check("abc_data", wr_log[k], exp_q[2][k]);
        check("abc_grant", grant_id, 2);
        check("abc_busy_low", busy, 0);

        // FIFO near full: no writes at 62, two writes resume from 60.
        clear_logs();
        level = 62;
        enq(0, 4, 1'b1);
        repeat (6) cycle();
        check("full_no_write", wr_log.size(), 0);
        check("full_busy", busy, 1);
        level    = 60;
        autofill = 1'b1;
        repeat (8) cycle();
        check("resume_writes", wr_log.size(), 2);
        check("resume_level", level, 62);
        autofill = 1'b0;
        level    = 0;
        run_until_idle("full_drain", 50);
        check("full_total", wr_log.size(), 4);

        // MAX_BEATS overrun from requester 1, then requester 2 served.
        do_reset();
        clear_logs();
        enq(1, 16, 1'b0);
        enq(2, 1, 1'b1);
        run_until_idle("overrun", 200);
        check("overrun_err_pulses", err_pulses, 1);
        check("overrun_count", wr_log.size(), 17);
        if (wr_log.size() == 17) begin
            for (int k = 0; k < 16; k++) check("overrun_data", wr_log[k], exp_q[1][k]);
            check("overrun_next", wr_log[16], exp_q[2][0]);
        end
        check("overrun_grants", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("overrun_g0", gnt_log[0], 1);
            check("overrun_g1", gnt_log[1], 2);
        end

        // Reset mid-burst after 2 of 4 beats.
        clear_logs();
        enq(3, 4, 1'b1);
        for (int c = 0; c < 30 && wr_log.size() < 2; c++) cycle();
        check("midrst_pre_writes", wr_log.size(), 2);
        rst = 1'b1;
        #1;
        check("midrst_ready", req_ready,  0);
        check("midrst_wr_en", fifo_wr_en, 0);
        check("midrst_wdata", fifo_wdata, 0);
        check("midrst_grant", grant_id,   0);
        check("midrst_busy",  busy,       0);
        check("midrst_err",   burst_err,  0);
        do_reset();
        clear_logs();
        repeat (3) cycle();
        check("midrst_no_write", wr_log.size(), 0);
        enq(0, 1, 1'b1);
        run_until_idle("midrst_new", 20);
        check("midrst_new_count", wr_log.size(), 1);
        if (wr_log.size() == 1) check("midrst_new_data", wr_log[0], exp_q[0][0]);
        check("midrst_new_grant", grant_id, 0);

        // Grantee with valid gaps (1 on, 2 off) while others wait.
        clear_logs();
        gap_mode[1] = 1'b1;
        gap_ctr[1]  = 0;
        enq(1, 4, 1'b1);
        cycle();
        enq(2, 1, 1'b1);
        enq(0, 1, 1'b1);
        run_until_idle("gaps", 100);
        check("gaps_count", wr_log.size(), 6);
        if (wr_log.size() == 6) begin
            for (int k = 0; k < 4; k++) check("gaps_data", wr_log[k], exp_q[1][k]);
            check("gaps_next2", wr_log[4], exp_q[2][0]);
            check("gaps_next0", wr_log[5], exp_q[0][0]);
        end
        cfg_default();

        // Random traffic with random valid duty, FIFO fill and drain.
        do_reset();
        clear_logs();
        total_enq = 0;
        autofill  = 1'b1;
        drain_pct = 40;
        level     = 50;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bq[i].size() < 8 && $urandom_range(99) < 6)
                    enq(i, int'($urandom_range(1, 20)), ($urandom_range(9) != 0));
                if ($urandom_range(19) == 0) valid_pct[i] = int'($urandom_range(30, 100));
            end
            cycle();
        end
        for (int i = 0; i < NUM_REQ; i++) valid_pct[i] = 100;
        drain_pct = 100;
        run_until_idle("random_drain", 2000);
        check("random_all_written", wr_log.size(), total_enq);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rah_resp_arbiter.md
RAH_RESP_ARBITER -- requirements
Module: rah_resp_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
- NUM_REQ, 4, number of response requesters (UART/GPIO/PWM controllers).
- PKT_WIDTH, 48, RAH packet beat width.
- FIFO_DEPTH, 64, depth of the downstream response FIFO.
- CNT_WIDTH, 8, width of the FIFO datacount.
- FULL_MARGIN, 2, free-slot reserve before backpressure.
- MAX_BEATS, 16, maximum beats per granted packet.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line; clock is single, reset is asynchronous active-high:
- clk, input, 1, sole clock.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester beat valid.
- req_data, input, NUM_REQ*PKT_WIDTH, beat data; requester i at [i*PKT_WIDTH +: PKT_WIDTH].
- req_last, input, NUM_REQ, final beat of the packet.
- req_ready, output, NUM_REQ, beat accepted when valid&ready.
- fifo_datacount, input, CNT_WIDTH, downstream FIFO occupancy.
- fifo_wr_en, output, 1, write strobe to the FIFO.
- fifo_wdata, output, PKT_WIDTH, write data to the FIFO.
- grant_id, output, $clog2(NUM_REQ), current or last grantee.
- busy, output, 1, high in state BURST.
- burst_err, output, 1, one-cycle pulse on MAX_BEATS overrun.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-004 In IDLE with any req_valid set, the block SHALL select the first set index searching from rr_ptr+1 upward with wrap-around, register it into grant_id, and enter BURST on the next edge.
REQ-005 In IDLE, req_ready SHALL be all zero; a valid asserted in IDLE is accepted no earlier than the second cycle.
REQ-006 space SHALL be defined as (fifo_datacount + fifo_wr_en) < (FIFO_DEPTH - FULL_MARGIN), computed at CNT_WIDTH+1 bits with no wrap.
REQ-007 In BURST, req_ready[grant_id] SHALL equal space, and all other req_ready bits SHALL be 0.
REQ-008 A beat SHALL be accepted when req_valid[g] & req_ready[g]; on the next edge fifo_wr_en=1 and fifo_wdata=the accepted data (fixed latency of 1 cycle).
REQ-009 When no beat is accepted, fifo_wr_en SHALL be 0 and fifo_wdata SHALL hold its last value.
REQ-010 Requesters SHALL hold data and last stable while valid and not ready; the block SHALL NOT drop or duplicate beats.
REQ-011 An accepted beat with req_last=1 SHALL return the FSM to IDLE and set rr_ptr to grant_id.
REQ-012 A beat counter SHALL clear on entering BURST and increment per accepted beat.
REQ-013 When the MAX_BEATS-th beat is accepted without last, the block SHALL pulse burst_err for 1 cycle, go to IDLE, and set rr_ptr to grant_id.
REQ-014 Deassertion of the grantee's valid mid-burst SHALL keep the grant; the block SHALL wait, with no timeout.
REQ-015 When space=0, req_ready SHALL be 0 and the FSM SHALL hold in BURST.
REQ-016 When all requesters are valid simultaneously, grants SHALL rotate strictly (0,1,2,3,0...) after reset.

Reset
REQ-017 On rst the block SHALL asynchronously set: state=IDLE, rr_ptr=NUM_REQ-1 (first grant goes to index 0), grant_id=0, beat counter=0, fifo_wr_en=0, fifo_wdata=0, burst_err=0, busy=0, req_ready=0.
REQ-018 A reset asserted mid-burst SHALL abandon the packet, and no fifo_wr_en SHALL follow the reset release.

Structure
REQ-019 PKT_WIDTH, FIFO_DEPTH, and the IDLE/BURST state encodings SHALL reside in the shared periplex.vh header alongside TOTAL_UART, TOTAL_GPIO_CTRLS, and TOTAL_PWM.
REQ-020 The round-robin priority selection SHALL be a sub-module rr_select (inputs: request vector, rr_ptr; outputs: index, any); the FSM and counters SHALL remain in the top module.

Verification
REQ-021 Bench: req 2 sends 3 beats (A,B,C; last on C), FIFO empty -> grant_id=2, fifo_wr_en high 3 cycles carrying A,B,C, busy falls after C.
REQ-022 Bench: all 4 requesters send 1-beat packets continuously -> write order 0,1,2,3,0, no starvation.
REQ-023 Bench: fifo_datacount=62 with FULL_MARGIN=2 -> req_ready=0 and no write; drop to 60 -> single-beat writes resume one per cycle until count+wr_en reaches 62.
REQ-024 Bench: req 1 sends 16 beats with no last -> 16 writes, burst_err pulses 1 cycle, and the next grant goes to index 2 if requesting.
REQ-025 Bench: rst asserted after 2 of 4 beats -> all outputs zero immediately; after release, a new request from 0 is granted cleanly.
REQ-026 Bench: grantee valid gaps (1 cycle on, 2 off) -> grant held, beats written in order, other requesters' ready stays 0.
